// File: rtl/extend_pkg.sv
// Shared types and widths for the ARM immediate extender.
// Optional feature macro used by this slice: EXTEND_ROT_EN (rotated DP immediates).
package extend_pkg;

    localparam int IN_W  = 24;
    localparam int OUT_W = 32;

    typedef enum logic [1:0] {
        IMM_DP8   = 2'b00,
        IMM_MEM12 = 2'b01,
        IMM_BR24  = 2'b10,
        IMM_RSVD  = 2'b11
    } imm_src_e;

    // Branch offset: sign-extend imm24 and scale to a byte offset.
    function automatic logic [OUT_W-1:0] branchImm(input logic [IN_W-1:0] data);
        return {{6{data[IN_W-1]}}, data, 2'b00};
    endfunction

endpackage

// File: rtl/extend_if.sv
// Request/response bundle between the control/datapath and the immediate extender.
interface extend_if;
    import extend_pkg::*;

    logic [IN_W-1:0]  theData;
    logic [1:0]       ImmSrc;
    logic             in_valid;
    logic [OUT_W-1:0] ExtImm;
    logic             out_valid;

    modport master (
        output theData, ImmSrc, in_valid,
        input  ExtImm, out_valid
    );

    modport slave (
        input  theData, ImmSrc, in_valid,
        output ExtImm, out_valid
    );

endinterface

// File: rtl/extend_imm_rotator.sv
// ARM data-processing immediate: zero-extended imm8 rotated right by twice rot.
module imm_rotator
    import extend_pkg::*;
(
    input  logic [7:0]       val_i,
    input  logic [3:0]       rot_i,
    output logic [OUT_W-1:0] res_o
);

    logic [OUT_W-1:0] src;
    logic [4:0]       amt;
    logic [5:0]       backAmt;

    assign src     = {24'b0, val_i};
    assign amt     = {rot_i, 1'b0};
    assign backAmt = 6'd32 - {1'b0, amt};

    // A left shift by 32 yields zero, so amt=0 degenerates to the plain value.
    assign res_o = (src >> amt) | (src << backAmt);

endmodule

// File: rtl/extend.sv
// Immediate extender with a one-cycle, valid-qualified output register.
// Define EXTEND_ROT_EN to make ImmSrc=00 produce the ARM rotated immediate.
module extend
    import extend_pkg::*;
(
    input logic   clk,
    input logic   rst_n,
    extend_if.slave bus
);

    logic [OUT_W-1:0] decoded;
    logic [OUT_W-1:0] dpImm;
    logic [OUT_W-1:0] extImm_d, extImm_q;
    logic             outValid_d, outValid_q;

`ifdef EXTEND_ROT_EN
    imm_rotator u_rot (
        .val_i (bus.theData[7:0]),
        .rot_i (bus.theData[11:8]),
        .res_o (dpImm)
    );
`else
    assign dpImm = {24'b0, bus.theData[7:0]};
`endif

    always_comb begin
        decoded = '0;
        case (imm_src_e'(bus.ImmSrc))
            IMM_DP8:   decoded = dpImm;
            IMM_MEM12: decoded = {20'b0, bus.theData[11:0]};
            IMM_BR24:  decoded = branchImm(bus.theData);
            IMM_RSVD:  decoded = '0;
            default:   decoded = '0;
        endcase
    end

    // Idle cycles keep the last immediate visible; only the valid drops.
    always_comb begin
        extImm_d   = extImm_q;
        outValid_d = bus.in_valid;
        if (bus.in_valid) begin
            extImm_d = decoded;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            extImm_q   <= '0;
            outValid_q <= 1'b0;
        end else begin
            extImm_q   <= extImm_d;
            outValid_q <= outValid_d;
        end
    end

    assign bus.ExtImm    = extImm_q;
    assign bus.out_valid = outValid_q;

endmodule

// File: tb/tb_extend.sv
// Scoreboard bench for extend: stimulus pushes expected results, a monitor pops on out_valid.
module tb_extend;
    import extend_pkg::*;

    typedef struct {
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    exp_t expQ[$];

    always #5 clk = ~clk;

    extend_if bus ();

    extend dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] src, input logic [23:0] data,
                                 input logic [31:0] exp, input string name);
        exp_t e;
        @(negedge clk);
        bus.ImmSrc   = src;
        bus.theData  = data;
        bus.in_valid = 1'b1;
        e.val  = exp;
        e.name = name;
        expQ.push_back(e);
    endtask

    // Monitor: every valid output must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got ExtImm=%h, expected no output", bus.ExtImm);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput(e.name, bus.ExtImm, e.val);
            end
        end
    end

    initial begin
        int n;
        bus.ImmSrc   = 2'b00;
        bus.theData  = '0;
        bus.in_valid = 1'b0;

        #1;
        checkOutput("reset_extimm", bus.ExtImm, 32'h0);
        checkOutput("reset_valid", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2'b00, 24'h132000, 32'h00000000, "dp_rot0");
        applyStimulus(2'b00, 24'h0000A5, 32'h000000A5, "dp_a5");
        applyStimulus(2'b01, 24'h132ABC, 32'h00000ABC, "mem_abc");
        applyStimulus(2'b01, 24'h000FFF, 32'h00000FFF, "mem_fff");
        applyStimulus(2'b10, 24'h800001, 32'hFE000004, "br_neg");
        applyStimulus(2'b10, 24'h000010, 32'h00000040, "br_pos");
        applyStimulus(2'b11, 24'hFFFFFF, 32'h00000000, "rsvd");
`ifdef EXTEND_ROT_EN
        applyStimulus(2'b00, 24'h0004FF, 32'hFF000000, "dp_rot4");
        applyStimulus(2'b00, 24'h000F01, 32'h00000004, "dp_rot15");
`else
        applyStimulus(2'b00, 24'h0004FF, 32'h000000FF, "dp_norot_ff");
        applyStimulus(2'b00, 24'h000F01, 32'h00000001, "dp_norot_01");
`endif
        applyStimulus(2'b01, 24'h000123, 32'h00000123, "hold_src");

        // Idle with changing inputs: the register must keep 0x123.
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.ImmSrc   = 2'b10;
        bus.theData  = 24'h7FFFFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checkOutput("hold_valid", {31'b0, bus.out_valid}, 32'h0);
            checkOutput("hold_value", bus.ExtImm, 32'h00000123);
        end

        // Mid-stream reset: the captured value is discarded before it is seen.
        applyStimulus(2'b01, 24'h000456, 32'h00000456, "discarded");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        expQ.delete();
        bus.in_valid = 1'b0;
        #1;
        checkOutput("midreset_extimm", bus.ExtImm, 32'h0);
        checkOutput("midreset_valid", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_reset_idle", {31'b0, bus.out_valid}, 32'h0);

        applyStimulus(2'b10, 24'hFFFFFF, 32'hFFFFFFFC, "first_after_reset");
        applyStimulus(2'b01, 24'h000001, 32'h00000001, "b2b_1");
        applyStimulus(2'b00, 24'h000002, 32'h00000002, "b2b_2");
        @(negedge clk);
        bus.in_valid = 1'b0;

        n = 0;
        while (expQ.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", expQ.size(), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
